triangle_rasterizer: RTL and testbench

TRIANGLE_RASTERIZER -- requirements
Module: triangle_rasterizer

---
 rtl/triangle_rasterizer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_triangle_rasterizer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_rasterizer.sv
// Flat-depth triangle rasterizer: latches one projected triangle, culls degenerate or
// off-screen cases, then walks the clamped bounding box one pixel per cycle using
// incremental edge functions and hands inside pixels out over a valid/ready port.
module triangle_rasterizer #(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned FB_HEIGHT   = 180
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      start,
    input  logic                                      tri_valid,
    input  logic signed [2:0][3:0][COORD_WIDTH-1:0]   projected_verts,
    input  logic                                      frag_ready,
    output logic                                      frag_valid,
    output logic [$clog2(FB_WIDTH)-1:0]               frag_x,
    output logic [$clog2(FB_HEIGHT)-1:0]              frag_y,
    output logic [COORD_WIDTH-1:0]                    frag_z,
    output logic                                      busy,
    output logic                                      done,
    output logic [1:0]                                status
);

    localparam int unsigned HW = COORD_WIDTH / 2;
    localparam int unsigned EW = 2 * HW + 4;
    localparam int unsigned XW = $clog2(FB_WIDTH);
    localparam int unsigned YW = $clog2(FB_HEIGHT);

    localparam logic signed [EW-1:0] X_LAST = EW'(FB_WIDTH - 1);
    localparam logic signed [EW-1:0] Y_LAST = EW'(FB_HEIGHT - 1);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_DEGEN     = 2'b01;
    localparam logic [1:0] ST_OFFSCREEN = 2'b10;
    localparam logic [1:0] ST_CULLED    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ORIENT,
        S_BBOX,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Latched triangle and working geometry
    logic signed [2:0][3:0][COORD_WIDTH-1:0] verts_q;
    logic                                    valid_q;
    logic signed [HW-1:0]                    vx [3];
    logic signed [HW-1:0]                    vy [3];
    logic [COORD_WIDTH-1:0]                  z0_q;

    // Scan window and current pixel
    logic [XW-1:0] xmin_q;
    logic [XW-1:0] xmax_q;
    logic [YW-1:0] ymin_q;
    logic [YW-1:0] ymax_q;
    logic [XW-1:0] px;
    logic [YW-1:0] py;

    // Edge function values at the current pixel and at the current row start
    logic signed [EW-1:0] edge_q     [3];
    logic signed [EW-1:0] edge_row_q [3];

    // Combinational helpers
    logic signed [EW-1:0] dx_c        [3];
    logic signed [EW-1:0] dy_c        [3];
    logic signed [EW-1:0] edge_init_c [3];
    logic signed [EW-1:0] area_c;
    logic signed [EW-1:0] xlo_c;
    logic signed [EW-1:0] xhi_c;
    logic signed [EW-1:0] ylo_c;
    logic signed [EW-1:0] yhi_c;
    logic signed [EW-1:0] xmin_cl_c;
    logic signed [EW-1:0] xmax_cl_c;
    logic signed [EW-1:0] ymin_cl_c;
    logic signed [EW-1:0] ymax_cl_c;
    logic                 cull_c;
    logic                 inside_c;
    logic                 last_c;
    logic                 handshake_c;
    logic                 advance_c;
    logic [1:0]           status_c;
    logic                 unused_c;

    function automatic logic signed [EW-1:0] min3(input logic signed [EW-1:0] a,
                                                  input logic signed [EW-1:0] b,
                                                  input logic signed [EW-1:0] c);
        logic signed [EW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [EW-1:0] max3(input logic signed [EW-1:0] a,
                                                  input logic signed [EW-1:0] b,
                                                  input logic signed [EW-1:0] c);
        logic signed [EW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Fractional parts, inv_w and the depth of vertices 1/2 are not used for flat coverage
    assign unused_c = ^{verts_q[0][3], verts_q[1][3], verts_q[2][3],
                        verts_q[1][2], verts_q[2][2],
                        verts_q[0][0][HW-1:0], verts_q[0][1][HW-1:0],
                        verts_q[1][0][HW-1:0], verts_q[1][1][HW-1:0],
                        verts_q[2][0][HW-1:0], verts_q[2][1][HW-1:0]};

    // Edge deltas, orientation, bounding box and initial edge values
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dx_c[i] = EW'(vx[(i + 1) % 3]) - EW'(vx[i]);
            dy_c[i] = EW'(vy[(i + 1) % 3]) - EW'(vy[i]);
        end

        area_c = (EW'(vx[1]) - EW'(vx[0])) * (EW'(vy[2]) - EW'(vy[0]))
               - (EW'(vy[1]) - EW'(vy[0])) * (EW'(vx[2]) - EW'(vx[0]));

        xlo_c = min3(EW'(vx[0]), EW'(vx[1]), EW'(vx[2]));
        xhi_c = max3(EW'(vx[0]), EW'(vx[1]), EW'(vx[2]));
        ylo_c = min3(EW'(vy[0]), EW'(vy[1]), EW'(vy[2]));
        yhi_c = max3(EW'(vy[0]), EW'(vy[1]), EW'(vy[2]));

        cull_c = xhi_c[EW-1] || (xlo_c > X_LAST) || yhi_c[EW-1] || (ylo_c > Y_LAST);

        xmin_cl_c = xlo_c[EW-1] ? '0 : xlo_c;
        ymin_cl_c = ylo_c[EW-1] ? '0 : ylo_c;
        xmax_cl_c = (xhi_c > X_LAST) ? X_LAST : xhi_c;
        ymax_cl_c = (yhi_c > Y_LAST) ? Y_LAST : yhi_c;

        for (int i = 0; i < 3; i++) begin
            edge_init_c[i] = dx_c[i] * (ymin_cl_c - EW'(vy[i]))
                           - dy_c[i] * (xmin_cl_c - EW'(vx[i]));
        end

        inside_c    = !edge_q[0][EW-1] && !edge_q[1][EW-1] && !edge_q[2][EW-1];
        last_c      = (px == xmax_q) && (py == ymax_q);
        handshake_c = frag_valid && frag_ready;
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_SETUP;
            S_SETUP:  state_next = valid_q ? S_ORIENT : S_DONE;
            S_ORIENT: state_next = (area_c == '0) ? S_DONE : S_BBOX;
            S_BBOX:   state_next = cull_c ? S_DONE : S_SCAN;
            S_SCAN: begin
                if (inside_c)    state_next = S_EMIT;
                else if (last_c) state_next = S_DONE;
            end
            S_EMIT: begin
                if (handshake_c) state_next = last_c ? S_DONE : S_SCAN;
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control strobes: pixel advance and completion code
    always_comb begin
        advance_c = 1'b0;
        status_c  = ST_OK;
        case (state)
            S_SETUP:  if (!valid_q) status_c = ST_CULLED;
            S_ORIENT: if (area_c == '0) status_c = ST_DEGEN;
            S_BBOX:   if (cull_c) status_c = ST_OFFSCREEN;
            S_SCAN:   advance_c = !inside_c && !last_c;
            S_EMIT:   advance_c = handshake_c && !last_c;
            default:  ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            verts_q    <= '0;
            valid_q    <= 1'b0;
            z0_q       <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            px         <= '0;
            py         <= '0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_z     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= '0;
            for (int i = 0; i < 3; i++) begin
                vx[i]         <= '0;
                vy[i]         <= '0;
                edge_q[i]     <= '0;
                edge_row_q[i] <= '0;
            end
        end else begin
            done <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                status <= status_c;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        verts_q <= projected_verts;
                        valid_q <= tri_valid;
                        busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    for (int i = 0; i < 3; i++) begin
                        vx[i] <= verts_q[i][0][COORD_WIDTH-1:HW];
                        vy[i] <= verts_q[i][1][COORD_WIDTH-1:HW];
                    end
                    z0_q <= verts_q[0][2];
                end
                S_ORIENT: begin
                    // Clockwise input is flipped so the inside test is always "all edges >= 0"
                    if (area_c[EW-1]) begin
                        vx[1] <= vx[2];
                        vx[2] <= vx[1];
                        vy[1] <= vy[2];
                        vy[2] <= vy[1];
                    end
                end
                S_BBOX: begin
                    xmin_q <= XW'(xmin_cl_c);
                    xmax_q <= XW'(xmax_cl_c);
                    ymin_q <= YW'(ymin_cl_c);
                    ymax_q <= YW'(ymax_cl_c);
                    px     <= XW'(xmin_cl_c);
                    py     <= YW'(ymin_cl_c);
                    for (int i = 0; i < 3; i++) begin
                        edge_q[i]     <= edge_init_c[i];
                        edge_row_q[i] <= edge_init_c[i];
                    end
                end
                S_SCAN: begin
                    if (inside_c) begin
                        frag_x     <= px;
                        frag_y     <= py;
                        frag_z     <= z0_q;
                        frag_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (handshake_c) begin
                        frag_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase

            // Incremental walk: +1 in x subtracts dy, a new row adds dx to the row start
            if (advance_c) begin
                if (px == xmax_q) begin
                    px <= xmin_q;
                    py <= py + 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        edge_row_q[i] <= edge_row_q[i] + dx_c[i];
                        edge_q[i]     <= edge_row_q[i] + dx_c[i];
                    end
                end else begin
                    px <= px + 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        edge_q[i] <= edge_q[i] - dy_c[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed and random triangles checked against a coverage model built from plain
// edge-function arithmetic over the clamped bounding box.
module tb_triangle_rasterizer;

    localparam int CW     = 32;
    localparam int FBW    = 320;
    localparam int FBH    = 180;
    localparam int XW     = $clog2(FBW);
    localparam int YW     = $clog2(FBH);
    localparam int BUDGET = 20000;

    logic                           clk_in = 1'b0;
    logic                           rst_in;
    logic                           start;
    logic                           tri_valid;
    logic signed [2:0][3:0][CW-1:0] projected_verts;
    logic                           frag_ready;
    logic                           frag_valid;
    logic [XW-1:0]                  frag_x;
    logic [YW-1:0]                  frag_y;
    logic [CW-1:0]                  frag_z;
    logic                           busy;
    logic                           done;
    logic [1:0]                     status;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [1:0]  exp_status;

    triangle_rasterizer #(
        .COORD_WIDTH(CW),
        .FB_WIDTH   (FBW),
        .FB_HEIGHT  (FBH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start          (start),
        .tri_valid      (tri_valid),
        .projected_verts(projected_verts),
        .frag_ready     (frag_ready),
        .frag_valid     (frag_valid),
        .frag_x         (frag_x),
        .frag_y         (frag_y),
        .frag_z         (frag_z),
        .busy           (busy),
        .done           (done),
        .status         (status)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint edge_fn(input longint xa, input longint ya,
                                       input longint xb, input longint yb,
                                       input longint qx, input longint qy);
        return (xb - xa) * (qy - ya) - (yb - ya) * (qx - xa);
    endfunction

    function automatic logic [63:0] pack_frag(input int x, input int y, input logic [31:0] z);
        return {16'(x), 16'(y), z};
    endfunction

    // Reference: every pixel of the clamped box whose three edge values share the winding sign
    task automatic build_model(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2, input logic [31:0] z, input bit valid);
        longint area, e0, e1, e2;
        int xlo, xhi, ylo, yhi;
        bit in;
        exp_q.delete();
        if (!valid) begin
            exp_status = 2'b11;
            return;
        end
        area = edge_fn(x0, y0, x1, y1, x2, y2);
        if (area == 0) begin
            exp_status = 2'b01;
            return;
        end
        xlo = (x0 < x1) ? x0 : x1;  xlo = (x2 < xlo) ? x2 : xlo;
        xhi = (x0 > x1) ? x0 : x1;  xhi = (x2 > xhi) ? x2 : xhi;
        ylo = (y0 < y1) ? y0 : y1;  ylo = (y2 < ylo) ? y2 : ylo;
        yhi = (y0 > y1) ? y0 : y1;  yhi = (y2 > yhi) ? y2 : yhi;
        if (xhi < 0 || xlo > FBW - 1 || yhi < 0 || ylo > FBH - 1) begin
            exp_status = 2'b10;
            return;
        end
        if (xlo < 0) xlo = 0;
        if (ylo < 0) ylo = 0;
        if (xhi > FBW - 1) xhi = FBW - 1;
        if (yhi > FBH - 1) yhi = FBH - 1;
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                e0 = edge_fn(x0, y0, x1, y1, x, y);
                e1 = edge_fn(x1, y1, x2, y2, x, y);
                e2 = edge_fn(x2, y2, x0, y0, x, y);
                if (area > 0) in = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
                else          in = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
                if (in) exp_q.push_back(pack_frag(x, y, z));
            end
        end
        exp_status = 2'b00;
    endtask

    // Integer pixel coordinates with random fractional bits, random inv_w and off-vertex depths
    task automatic set_verts(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input logic [31:0] z);
        int xs[3];
        int ys[3];
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        for (int v = 0; v < 3; v++) begin
            projected_verts[v][0] = {16'(xs[v]), 16'($urandom)};
            projected_verts[v][1] = {16'(ys[v]), 16'($urandom)};
            projected_verts[v][2] = (v == 0) ? z : 32'($urandom);
            projected_verts[v][3] = 32'($urandom);
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 five-cycle stall on the third fragment
    task automatic run_tri(input string name, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input logic [31:0] z,
                           input bit valid, input int rmode, input bit chk_lat, input bit poke);
        int          k = 0;
        int          nseen = 0;
        int          first_valid = -1;
        int          stall_cnt = 0;
        bit          done_seen = 1'b0;
        bit          r;
        bit          prev_valid = 1'b0;
        bit          prev_r = 1'b1;
        logic [63:0] prev_frag = '0;
        logic [63:0] cur;
        logic [1:0]  st = 2'b00;
        int          n;

        build_model(x0, y0, x1, y1, x2, y2, z, valid);
        obs_q.delete();
        set_verts(x0, y0, x1, y1, x2, y2, z);
        tri_valid = valid;
        start     = 1'b1;

        while (!done_seen && k < BUDGET) begin
            @(negedge clk_in);
            k++;
            start = 1'b0;
            if (poke && busy && (k % 3 == 0)) begin
                start                 = 1'b1;
                tri_valid             = 1'b0;
                projected_verts[0][0] = 32'($urandom);
                projected_verts[1][1] = 32'($urandom);
            end
            if (k == 1) check({name, "_busy_after_start"}, 64'(busy), 64'(1));
            cur = {16'(frag_x), 16'(frag_y), frag_z};
            if (prev_valid && !prev_r) begin
                check({name, "_hold_valid"}, 64'(frag_valid), 64'(1));
                check({name, "_hold_frag"}, cur, prev_frag);
            end
            if (frag_valid && first_valid < 0) first_valid = k;
            r = 1'b1;
            if (rmode == 1) r = 1'($urandom_range(0, 1));
            if (rmode == 2 && frag_valid && nseen == 2 && stall_cnt < 5) begin
                r = 1'b0;
                stall_cnt++;
            end
            frag_ready = r;
            if (frag_valid && r) begin
                obs_q.push_back(cur);
                nseen++;
            end
            prev_valid = frag_valid;
            prev_r     = r;
            prev_frag  = cur;
            if (done) begin
                done_seen = 1'b1;
                st        = status;
            end
        end
        start      = 1'b0;
        frag_ready = 1'b1;

        check({name, "_done_seen"}, 64'(done_seen), 64'(1));
        check({name, "_status"}, 64'(st), 64'(exp_status));
        check({name, "_frag_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_frag%0d", name, i), obs_q[i], exp_q[i]);
        end
        if (chk_lat) check({name, "_first_valid_cycle"}, 64'(first_valid), 64'(5));

        @(negedge clk_in);
        check({name, "_busy_cleared"}, 64'(busy), 64'(0));
        check({name, "_done_one_cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        int  k;
        int  nseen;
        bit  hit;
        int  rx[3];
        int  ry[3];

        rst_in          = 1'b0;
        start           = 1'b0;
        tri_valid       = 1'b0;
        frag_ready      = 1'b1;
        projected_verts = '0;

        repeat (2) @(negedge clk_in);
        check("reset_frag_valid", 64'(frag_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_status", 64'(status), 64'(0));
        check("reset_frag_xyz", {16'(frag_x), 16'(frag_y), frag_z}, 64'(0));
        rst_in = 1'b1;
        @(negedge clk_in);

        run_tri("ccw_basic", 0, 0, 3, 0, 0, 3, 32'h0000_8000, 1'b1, 0, 1'b1, 1'b0);
        check("ccw_basic_ten", 64'(obs_q.size()), 64'(10));
        check("ccw_basic_last", obs_q.size() > 0 ? obs_q[obs_q.size()-1] : '0,
              {16'd0, 16'd3, 32'h0000_8000});
        run_tri("cw_swapped", 0, 0, 0, 3, 3, 0, 32'h0000_8000, 1'b1, 0, 1'b1, 1'b0);
        check("cw_swapped_ten", 64'(obs_q.size()), 64'(10));
        run_tri("collinear", 0, 0, 2, 2, 4, 4, 32'($urandom), 1'b1, 0, 1'b0, 1'b0);
        run_tri("not_valid", 1, 1, 9, 2, 3, 8, 32'($urandom), 1'b0, 0, 1'b0, 1'b0);
        run_tri("offscreen", -10, -10, -5, -10, -10, -5, 32'($urandom), 1'b1, 0, 1'b0, 1'b0);
        run_tri("straddle_x0", -3, 0, 3, 0, 0, 4, 32'($urandom), 1'b1, 0, 1'b0, 1'b0);
        run_tri("straddle_far", 310, 170, 330, 172, 312, 190, 32'($urandom), 1'b1, 1, 1'b0, 1'b0);
        run_tri("stall", 0, 0, 3, 0, 0, 3, 32'h0000_8000, 1'b1, 2, 1'b1, 1'b1);

        // Reset while the fifth fragment is being presented
        build_model(0, 0, 3, 0, 0, 3, 32'h0000_8000, 1'b1);
        set_verts(0, 0, 3, 0, 0, 3, 32'h0000_8000);
        tri_valid  = 1'b1;
        frag_ready = 1'b1;
        start      = 1'b1;
        k     = 0;
        nseen = 0;
        hit   = 1'b0;
        while (!hit && k < 200) begin
            @(negedge clk_in);
            k++;
            start = 1'b0;
            if (frag_valid) begin
                if (nseen == 4) hit = 1'b1;
                else nseen++;
            end
        end
        check("midrst_reached_fifth", 64'(hit), 64'(1));
        rst_in = 1'b0;
        #1;
        check("midrst_frag_valid", 64'(frag_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check($sformatf("midrst_no_done%0d", i), 64'(done), 64'(0));
        end
        rst_in = 1'b1;
        run_tri("after_reset", 0, 0, 3, 0, 0, 3, 32'h0000_8000, 1'b1, 0, 1'b1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            for (int v = 0; v < 3; v++) begin
                rx[v] = int'($urandom_range(0, 30)) - 10;
                ry[v] = int'($urandom_range(0, 30)) - 10;
            end
            run_tri($sformatf("rand%0d", t), rx[0], ry[0], rx[1], ry[1], rx[2], ry[2],
                    32'($urandom), ($urandom_range(0, 7) != 0), 1, 1'b0,
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
